// File: rtl/conv3x3_stream.sv
// rtl/conv3x3_stream.sv - streaming 3x3 valid-mode convolution with two line buffers
// Pixel accepted on edge N reaches the output register on edge N+2: window, sum, clamp.
module conv3x3_stream #(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int MAX_WIDTH = 256,
    parameter int SHIFT     = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic [$clog2(MAX_WIDTH+1)-1:0]   cfg_width,
    input  logic [15:0]                      cfg_height,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    input  logic                             k_we,
    input  logic [3:0]                       k_addr,
    input  logic signed [COEF_W-1:0]         k_data,
    input  logic                             in_valid,
    input  logic [DATA_W-1:0]                in_data,
    output logic                             in_ready,
    output logic                             out_valid,
    output logic [DATA_W-1:0]                out_data,
    input  logic                             out_ready
);

    localparam int CW    = $clog2(MAX_WIDTH+1);
    localparam int AW    = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int PW    = DATA_W + COEF_W + 1;
    localparam int ACC_W = DATA_W + COEF_W + 5;
    localparam logic signed [ACC_W-1:0] PIX_MAX = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [CW-1:0]             r_cfg_w;
    logic [15:0]               r_cfg_h;
    logic [AW-1:0]             r_col;
    logic [15:0]               r_row;
    logic signed [COEF_W-1:0]  r_coef [0:8];
    logic [DATA_W-1:0]         r_lb0 [0:MAX_WIDTH-1];
    logic [DATA_W-1:0]         r_lb1 [0:MAX_WIDTH-1];
    logic [DATA_W-1:0]         r_win [0:2][0:2];
    logic                      r_s1_v;
    logic                      r_s2_v;
    logic                      r_out_v;
    logic                      r_err;
    logic signed [ACC_W-1:0]   r_sum;
    logic [DATA_W-1:0]         r_out_data;

    logic                      w_cfg_ok;
    logic                      w_start_ok;
    logic                      w_stall;
    logic                      w_advance;
    logic                      w_accept;
    logic                      w_last_col;
    logic                      w_last_row;
    logic                      w_pos;
    logic                      w_done;
    logic signed [PW-1:0]      w_px;
    logic signed [PW-1:0]      w_k;
    logic signed [PW-1:0]      w_prod;
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [ACC_W-1:0]   w_shifted;
    logic [DATA_W-1:0]         w_clamped;

    assign w_cfg_ok   = (cfg_width >= CW'(3)) && (cfg_width <= CW'(MAX_WIDTH)) && (cfg_height >= 16'd3);
    assign w_start_ok = en && start && (r_state == S_IDLE) && w_cfg_ok;
    assign w_stall    = r_out_v && !out_ready;
    assign w_advance  = en && !w_stall;
    assign in_ready   = en && (r_state == S_RUN) && !w_stall;
    assign w_accept   = in_valid && in_ready;
    assign w_last_col = (CW'(r_col) == (r_cfg_w - 1'b1));
    assign w_last_row = (r_row == (r_cfg_h - 16'd1));
    assign w_pos      = (r_row >= 16'd2) && (r_col >= AW'(2));
    // Last handshake of the frame: nothing left behind it in the pipeline.
    assign w_done     = en && (r_state == S_DRAIN) && r_out_v && out_ready && !r_s1_v && !r_s2_v;

    assign busy      = (r_state != S_IDLE);
    assign done      = w_done;
    assign err       = r_err;
    assign out_valid = r_out_v;
    assign out_data  = r_out_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_next = S_RUN;
            S_RUN:   if (w_accept && w_last_col && w_last_row) w_next = S_DRAIN;
            S_DRAIN: if (w_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_px   = '0;
        w_k    = '0;
        w_prod = '0;
        w_sum  = '0;
        for (int i = 0; i < 9; i++) begin
            w_px   = {{(PW-DATA_W){1'b0}}, r_win[i/3][i%3]};
            w_k    = {{(PW-COEF_W){r_coef[i][COEF_W-1]}}, r_coef[i]};
            w_prod = w_px * w_k;
            w_sum  = w_sum + {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
        end
    end

    always_comb begin
        w_shifted = r_sum >>> SHIFT;
        if (w_shifted[ACC_W-1]) begin
            w_clamped = '0;
        end else if (w_shifted > PIX_MAX) begin
            w_clamped = '1;
        end else begin
            w_clamped = w_shifted[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_w    <= '0;
            r_cfg_h    <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_err      <= 1'b0;
            r_s1_v     <= 1'b0;
            r_s2_v     <= 1'b0;
            r_out_v    <= 1'b0;
            r_sum      <= '0;
            r_out_data <= '0;
            for (int i = 0; i < 9; i++) r_coef[i] <= '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) r_win[r][c] <= '0;
        end else begin
            r_err <= en && start && (r_state == S_IDLE) && !w_cfg_ok;
            if (w_start_ok) begin
                r_cfg_w <= cfg_width;
                r_cfg_h <= cfg_height;
                r_col   <= '0;
                r_row   <= '0;
            end
            if (en && (r_state == S_IDLE) && k_we && (k_addr <= 4'd8)) begin
                r_coef[k_addr] <= k_data;
            end
            if (w_accept) begin
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= r_lb1[r_col];
                r_win[1][2] <= r_lb0[r_col];
                r_win[2][2] <= in_data;
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= r_row + 16'd1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            // Output register reloads whenever it is empty or being drained, so no bubble.
            if (w_advance) begin
                r_s1_v  <= w_accept && w_pos;
                r_s2_v  <= r_s1_v;
                r_out_v <= r_s2_v;
                if (r_s1_v) r_sum <= w_sum;
                if (r_s2_v) r_out_data <= w_clamped;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[r_col] <= r_lb0[r_col];
            r_lb0[r_col] <= in_data;
        end
    end

endmodule
